// File: rtl/alu_mc_if.sv
// rtl/alu_mc_if.sv - request/result bundle between an alu_mc and its user
// Purpose: carries one request (valid/ready, opcode, operands, shift index)
//   into the block and one result (valid/ready, result word, flags) out.
// Ports (signals):
//   i_valid, i_opcode[3:0], i_wordA/B[WIDTH-1:0], i_shamt[SHW-1:0] : request
//   o_ready                                                        : block idle
//   o_valid, o_result[WIDTH-1:0], o_flag_equal, o_flag_notequal,
//   o_illegal                                                      : result
//   i_ready                                                        : result taken
// Modports: master = requester/consumer side, slave = alu_mc side.
interface alu_mc_if #(
  parameter int WIDTH = 32,
  parameter int SHW   = $clog2(WIDTH)
);
  logic             i_valid;
  logic             o_ready;
  logic [3:0]       i_opcode;
  logic [WIDTH-1:0] i_wordA;
  logic [WIDTH-1:0] i_wordB;
  logic [SHW-1:0]   i_shamt;
  logic             o_valid;
  logic             i_ready;
  logic [WIDTH-1:0] o_result;
  logic             o_flag_equal;
  logic             o_flag_notequal;
  logic             o_illegal;

  modport master (
    output i_valid, i_opcode, i_wordA, i_wordB, i_shamt, i_ready,
    input  o_ready, o_valid, o_result, o_flag_equal, o_flag_notequal, o_illegal
  );

  modport slave (
    input  i_valid, i_opcode, i_wordA, i_wordB, i_shamt, i_ready,
    output o_ready, o_valid, o_result, o_flag_equal, o_flag_notequal, o_illegal
  );
endinterface

// File: rtl/alu_mc.sv
// rtl/alu_mc.sv - multi-cycle ALU with optional shift-add multiply / restoring divide
// Purpose: accepts one operation at a time, returns a registered result and
//   equal/not-equal flags. Opcodes 0x0-0xC finish one cycle after accept.
//   Opcodes 0xD (MUL), 0xE (DIVU), 0xF (REMU) take WIDTH+1 cycles when the
//   macro ALU_MC_MULDIV_EN is defined; otherwise they finish in one cycle
//   with o_result=0 and o_illegal=1.
// Ports:
//   i_clk  : clock, rising edge
//   i_rst  : asynchronous active-high reset
//   bus    : alu_mc_if.slave (request, result and handshake signals)
module alu_mc #(
  parameter int WIDTH = 32,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic     i_clk,
  input  logic     i_rst,
  alu_mc_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

  state_t           state_q;
  logic             ready_q;
  logic             valid_q;
  logic [WIDTH-1:0] result_q;
  logic             eq_q;
  logic             ne_q;
  logic             ill_q;

  logic [WIDTH-1:0] alu_d;
  logic [WIDTH-1:0] bit_mask;
  logic             multi_d;

  // Single-cycle datapath, evaluated on the live request inputs.
  // Shifting by >= WIDTH naturally yields zero (or sign fill for SRA).
  always_comb begin
    bit_mask = ONE << bus.i_shamt;
    multi_d  = (bus.i_opcode >= 4'hD);
    alu_d    = '0;
    case (bus.i_opcode)
      4'h0: alu_d = bus.i_wordA + bus.i_wordB;
      4'h1: alu_d = bus.i_wordA - bus.i_wordB;
      4'h2: alu_d = bus.i_wordA & bus.i_wordB;
      4'h3: alu_d = bus.i_wordA | bus.i_wordB;
      4'h4: alu_d = ~(bus.i_wordA | bus.i_wordB);
      4'h5: alu_d = bus.i_wordA ^ bus.i_wordB;
      4'h6: alu_d = bus.i_wordA << bus.i_shamt;
      4'h7: alu_d = bus.i_wordA >> bus.i_shamt;
      4'h8: alu_d = $unsigned($signed(bus.i_wordA) >>> bus.i_shamt);
      4'h9: alu_d[0] = ($signed(bus.i_wordA) < $signed(bus.i_wordB));
      4'hA: alu_d[0] = (bus.i_wordA < bus.i_wordB);
      4'hB: alu_d = bus.i_wordA | bit_mask;
      4'hC: alu_d = bus.i_wordA & ~bit_mask;
      default: alu_d = '0;
    endcase
  end

`ifdef ALU_MC_MULDIV_EN
  localparam logic [SHW-1:0] LAST = SHW'(WIDTH - 1);

  // a_q: multiplicand (MUL) or dividend shifting into quotient (DIV)
  // b_q: multiplier (MUL) or divisor (DIV)
  // acc_q: product accumulator (MUL) or partial remainder (DIV)
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH-1:0] acc_q;
  logic [SHW-1:0]   cnt_q;
  logic [1:0]       kind_q;   // opcode low bits: 01 MUL, 10 DIVU, 11 REMU

  logic [WIDTH-1:0] mul_acc_d;
  logic [WIDTH:0]   rem_shift;
  logic [WIDTH:0]   trial;
  logic [WIDTH-1:0] div_rem_d;
  logic [WIDTH-1:0] div_quo_d;

  // One step of each iterative algorithm. A zero divisor never restores,
  // so the quotient fills with ones and the remainder ends up equal to A.
  always_comb begin
    mul_acc_d = b_q[0] ? (acc_q + a_q) : acc_q;
    rem_shift = {acc_q, a_q[WIDTH-1]};
    trial     = rem_shift - {1'b0, b_q};
    if (trial[WIDTH]) begin
      div_rem_d = rem_shift[WIDTH-1:0];
      div_quo_d = {a_q[WIDTH-2:0], 1'b0};
    end else begin
      div_rem_d = trial[WIDTH-1:0];
      div_quo_d = {a_q[WIDTH-2:0], 1'b1};
    end
  end
`endif

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q  <= IDLE;
      ready_q  <= 1'b1;
      valid_q  <= 1'b0;
      result_q <= '0;
      eq_q     <= 1'b0;
      ne_q     <= 1'b0;
      ill_q    <= 1'b0;
`ifdef ALU_MC_MULDIV_EN
      a_q      <= '0;
      b_q      <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
      kind_q   <= 2'b00;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.i_valid) begin
            ready_q <= 1'b0;
            eq_q    <= (bus.i_wordA == bus.i_wordB);
            ne_q    <= (bus.i_wordA != bus.i_wordB);
`ifdef ALU_MC_MULDIV_EN
            ill_q   <= 1'b0;
            if (multi_d) begin
              state_q <= BUSY;
              a_q     <= bus.i_wordA;
              b_q     <= bus.i_wordB;
              acc_q   <= '0;
              cnt_q   <= '0;
              kind_q  <= bus.i_opcode[1:0];
            end else begin
              state_q  <= DONE;
              valid_q  <= 1'b1;
              result_q <= alu_d;
            end
`else
            state_q  <= DONE;
            valid_q  <= 1'b1;
            result_q <= multi_d ? '0 : alu_d;
            ill_q    <= multi_d;
`endif
          end
        end
`ifdef ALU_MC_MULDIV_EN
        BUSY: begin
          cnt_q <= cnt_q + SHW'(1);
          if (kind_q == 2'b01) begin
            acc_q <= mul_acc_d;
            a_q   <= a_q << 1;
            b_q   <= b_q >> 1;
          end else begin
            acc_q <= div_rem_d;
            a_q   <= div_quo_d;
          end
          if (cnt_q == LAST) begin
            state_q <= DONE;
            valid_q <= 1'b1;
            case (kind_q)
              2'b01:   result_q <= mul_acc_d;
              2'b10:   result_q <= div_quo_d;
              default: result_q <= div_rem_d;
            endcase
          end
        end
`endif
        DONE: begin
          if (bus.i_ready) begin
            state_q <= IDLE;
            valid_q <= 1'b0;
            ready_q <= 1'b1;
          end
        end
        default: begin
          state_q <= IDLE;
          valid_q <= 1'b0;
          ready_q <= 1'b1;
        end
      endcase
    end
  end

  assign bus.o_ready         = ready_q;
  assign bus.o_valid         = valid_q;
  assign bus.o_result        = result_q;
  assign bus.o_flag_equal    = eq_q;
  assign bus.o_flag_notequal = ne_q;
  assign bus.o_illegal       = ill_q;

endmodule

// File: tb/tb_alu_mc.sv
// tb/tb_alu_mc.sv - self-checking bench for alu_mc (WIDTH=32)
module tb_alu_mc;
  localparam int W  = 32;
  localparam int SW = 5;
`ifdef ALU_MC_MULDIV_EN
  localparam bit MULDIV = 1'b1;
`else
  localparam bit MULDIV = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total = 0;
  int   bad   = 0;

  alu_mc_if #(.WIDTH(W), .SHW(SW)) bus ();
  alu_mc #(.WIDTH(W), .SHW(SW)) dut (.i_clk(clk), .i_rst(rst), .bus(bus));

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  // Reference model: plain arithmetic on wide integers.
  function automatic logic [31:0] model(input logic [3:0] op, input logic [31:0] a,
                                        input logic [31:0] b, input logic [4:0] sh);
    longint unsigned ua = a;
    longint unsigned ub = b;
    int              sa = a;
    int              sb = b;
    case (op)
      4'h0: return 32'(ua + ub);
      4'h1: return 32'(ua - ub);
      4'h2: return a & b;
      4'h3: return a | b;
      4'h4: return ~(a | b);
      4'h5: return a ^ b;
      4'h6: return 32'(ua << sh);
      4'h7: return 32'(ua >> sh);
      4'h8: return 32'(sa >>> sh);
      4'h9: return (sa < sb) ? 32'd1 : 32'd0;
      4'hA: return (ua < ub) ? 32'd1 : 32'd0;
      4'hB: return 32'(ua | (64'd1 << sh));
      4'hC: return 32'(ua & ~(64'd1 << sh));
      default: begin
        if (!MULDIV) return 32'd0;
        if (op == 4'hD) return 32'(ua * ub);
        if (op == 4'hE) return (ub == 0) ? 32'hFFFF_FFFF : 32'(ua / ub);
        return (ub == 0) ? a : 32'(ua % ub);
      end
    endcase
  endfunction

  function automatic int exp_lat(input logic [3:0] op);
    return (MULDIV && op >= 4'hD) ? W + 1 : 1;
  endfunction

  // Presents a request, waits for o_valid (bounded) while scrambling inputs,
  // leaves the result unconsumed.
  task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] sh, output int lat, output bit rdy_seen);
    @(negedge clk);
    bus.i_opcode = op; bus.i_wordA = a; bus.i_wordB = b; bus.i_shamt = sh;
    bus.i_valid  = 1'b1; bus.i_ready = 1'b0;
    @(posedge clk); #1;
    lat = 1;
    rdy_seen = bus.o_ready;
    while (!bus.o_valid && lat < 200) begin
      bus.i_valid = 1'(($urandom_range(0, 1)));
      bus.i_opcode = 4'($urandom); bus.i_wordA = $urandom; bus.i_wordB = $urandom;
      bus.i_shamt = 5'($urandom);
      @(posedge clk); #1;
      lat++;
      if (!bus.o_valid && bus.o_ready) rdy_seen = 1'b1;
    end
  endtask

  task automatic release_result();
    @(negedge clk);
    bus.i_valid = 1'b0; bus.i_ready = 1'b1;
    @(posedge clk); #1;
    bus.i_ready = 1'b0;
  endtask

  task automatic test_reset();
    bus.i_valid = 0; bus.i_ready = 0; bus.i_opcode = 0;
    bus.i_wordA = 0; bus.i_wordB = 0; bus.i_shamt = 0;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk); rst = 1'b0; #1;
    total++; if (bus.o_ready !== 1'b1) begin bad++; $display("FAIL reset_ready got=%b exp=1", bus.o_ready); end
    total++; if (bus.o_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b exp=0", bus.o_valid); end
    total++; if (bus.o_result !== 32'h0) begin bad++; $display("FAIL reset_result got=%h exp=0", bus.o_result); end
    total++; if (bus.o_flag_equal !== 1'b0 || bus.o_flag_notequal !== 1'b0) begin
      bad++; $display("FAIL reset_flags got=%b%b exp=00", bus.o_flag_equal, bus.o_flag_notequal); end
    total++; if (bus.o_illegal !== 1'b0) begin bad++; $display("FAIL reset_illegal got=%b exp=0", bus.o_illegal); end
  endtask

  task automatic test_directed();
    logic [3:0]  ops [10] = '{4'h0, 4'h8, 4'h9, 4'hA, 4'h6, 4'h7, 4'hB, 4'hC, 4'h1, 4'h4};
    logic [31:0] as  [10] = '{32'hFFFF_FFFF, 32'h8000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h1,
                              32'h8000_0000, 32'h0, 32'hFFFF_FFFF, 32'h0, 32'h0};
    logic [31:0] bs  [10] = '{32'h1, 32'h0, 32'h1, 32'h1, 32'h0, 32'h0, 32'h0, 32'h0, 32'h1, 32'h0};
    logic [4:0]  shs [10] = '{5'd0, 5'd4, 5'd0, 5'd0, 5'd31, 5'd31, 5'd31, 5'd0, 5'd0, 5'd0};
    logic [31:0] exs [10] = '{32'h0, 32'hF800_0000, 32'h1, 32'h0, 32'h8000_0000, 32'h1,
                              32'h8000_0000, 32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
    int lat; bit rs;
    for (int i = 0; i < 10; i++) begin
      issue(ops[i], as[i], bs[i], shs[i], lat, rs);
      total++; if (bus.o_result !== exs[i]) begin bad++;
        $display("FAIL directed_%0d_result got=%h exp=%h", i, bus.o_result, exs[i]); end
      total++; if (lat !== 1) begin bad++; $display("FAIL directed_%0d_latency got=%0d exp=1", i, lat); end
      total++; if (bus.o_flag_notequal !== (as[i] != bs[i]) || bus.o_flag_equal !== (as[i] == bs[i])) begin bad++;
        $display("FAIL directed_%0d_flags got=eq%b ne%b", i, bus.o_flag_equal, bus.o_flag_notequal); end
      release_result();
    end
  endtask

  task automatic test_random();
    logic [3:0] op; logic [31:0] a, b, e; logic [4:0] sh; int lat; bit rs;
    logic [31:0] edges [4] = '{32'h0, 32'hFFFF_FFFF, 32'h8000_0000, 32'h7FFF_FFFF};
    for (int i = 0; i < 60; i++) begin
      op = 4'($urandom_range(0, 15));
      a  = ($urandom_range(0, 4) == 0) ? edges[$urandom_range(0, 3)] : $urandom;
      b  = ($urandom_range(0, 3) == 0) ? a : (($urandom_range(0, 5) == 0) ? 32'h0 : $urandom);
      sh = 5'($urandom);
      e  = model(op, a, b, sh);
      issue(op, a, b, sh, lat, rs);
      total++; if (bus.o_result !== e) begin bad++;
        $display("FAIL rand_result op=%h a=%h b=%h sh=%0d got=%h exp=%h", op, a, b, sh, bus.o_result, e); end
      total++; if (lat !== exp_lat(op) || rs !== 1'b0) begin bad++;
        $display("FAIL rand_timing op=%h lat got=%0d exp=%0d ready_seen=%b", op, lat, exp_lat(op), rs); end
      total++; if (bus.o_illegal !== (!MULDIV && op >= 4'hD) || bus.o_flag_equal !== (a == b)
                   || bus.o_flag_notequal !== (a != b)) begin bad++;
        $display("FAIL rand_flags op=%h got ill=%b eq=%b ne=%b", op, bus.o_illegal, bus.o_flag_equal, bus.o_flag_notequal); end
      release_result();
      total++; if (bus.o_ready !== 1'b1 || bus.o_valid !== 1'b0) begin bad++;
        $display("FAIL rand_return_idle got ready=%b valid=%b exp ready=1 valid=0", bus.o_ready, bus.o_valid); end
    end
  endtask

  task automatic test_muldiv();
    logic [3:0]  ops [5] = '{4'hD, 4'hE, 4'hF, 4'hE, 4'hF};
    logic [31:0] as  [5] = '{32'h0001_2345, 32'd100, 32'd100, 32'd5, 32'd5};
    logic [31:0] bs  [5] = '{32'h0001_0000, 32'd7, 32'd7, 32'd0, 32'd0};
`ifdef ALU_MC_MULDIV_EN
    logic [31:0] exs [5] = '{32'h2345_0000, 32'd14, 32'd2, 32'hFFFF_FFFF, 32'd5};
    int          el = 33;
    bit          ei = 1'b0;
`else
    logic [31:0] exs [5] = '{32'h0, 32'h0, 32'h0, 32'h0, 32'h0};
    int          el = 1;
    bit          ei = 1'b1;
`endif
    int lat; bit rs;
    for (int i = 0; i < 5; i++) begin
      issue(ops[i], as[i], bs[i], 5'd0, lat, rs);
      total++; if (bus.o_result !== exs[i]) begin bad++;
        $display("FAIL muldiv_%0d_result got=%h exp=%h", i, bus.o_result, exs[i]); end
      total++; if (lat !== el || rs !== 1'b0) begin bad++;
        $display("FAIL muldiv_%0d_timing lat got=%0d exp=%0d ready_seen=%b", i, lat, el, rs); end
      total++; if (bus.o_illegal !== ei) begin bad++;
        $display("FAIL muldiv_%0d_illegal got=%b exp=%b", i, bus.o_illegal, ei); end
      release_result();
    end
  endtask

  task automatic test_hold();
    logic [31:0] a = 32'h1234_5678, b = 32'h0FED_CBA9, e;
    int lat; bit rs;
    e = a ^ b;
    issue(4'h5, a, b, 5'd3, lat, rs);
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      bus.i_valid = 1'(c & 1); bus.i_opcode = 4'($urandom);
      bus.i_wordA = $urandom; bus.i_wordB = $urandom; bus.i_shamt = 5'($urandom);
      @(posedge clk); #1;
      total++; if (bus.o_result !== e || bus.o_valid !== 1'b1 || bus.o_ready !== 1'b0
                   || bus.o_flag_notequal !== 1'b1 || bus.o_flag_equal !== 1'b0 || bus.o_illegal !== 1'b0) begin bad++;
        $display("FAIL hold_cycle_%0d got result=%h valid=%b ready=%b exp result=%h valid=1 ready=0",
                 c, bus.o_result, bus.o_valid, bus.o_ready, e); end
    end
    release_result();
    total++; if (bus.o_ready !== 1'b1 || bus.o_valid !== 1'b0) begin bad++;
      $display("FAIL hold_release got ready=%b valid=%b exp ready=1 valid=0", bus.o_ready, bus.o_valid); end
  endtask

  task automatic test_back_to_back();
    @(negedge clk);
    bus.i_opcode = 4'h0; bus.i_wordA = 32'd10; bus.i_wordB = 32'd20; bus.i_shamt = 0;
    bus.i_valid = 1'b1; bus.i_ready = 1'b1;
    @(posedge clk); #1;
    total++; if (bus.o_valid !== 1'b1 || bus.o_result !== 32'd30) begin bad++;
      $display("FAIL b2b_first got valid=%b result=%h exp valid=1 result=1e", bus.o_valid, bus.o_result); end
    bus.i_opcode = 4'h1; bus.i_wordA = 32'd50; bus.i_wordB = 32'd8;
    @(posedge clk); #1;
    total++; if (bus.o_valid !== 1'b0 || bus.o_ready !== 1'b1) begin bad++;
      $display("FAIL b2b_gap got valid=%b ready=%b exp valid=0 ready=1", bus.o_valid, bus.o_ready); end
    @(posedge clk); #1;
    total++; if (bus.o_valid !== 1'b1 || bus.o_result !== 32'd42) begin bad++;
      $display("FAIL b2b_second got valid=%b result=%h exp valid=1 result=2a", bus.o_valid, bus.o_result); end
    bus.i_valid = 1'b0;
    @(posedge clk); #1;
    bus.i_ready = 1'b0;
    total++; if (bus.o_ready !== 1'b1) begin bad++; $display("FAIL b2b_end got ready=%b exp=1", bus.o_ready); end
  endtask

  task automatic test_reset_abort();
    int lat; bit rs;
    @(negedge clk);
    bus.i_opcode = MULDIV ? 4'hE : 4'h0; bus.i_wordA = 32'd100; bus.i_wordB = 32'd7;
    bus.i_shamt = 0; bus.i_valid = 1'b1; bus.i_ready = 1'b0;
    @(posedge clk); #1;
    bus.i_valid = 1'b0;
    repeat (10) @(posedge clk);
    #2; rst = 1'b1; #1;
    total++; if (bus.o_valid !== 1'b0 || bus.o_result !== 32'h0 || bus.o_flag_notequal !== 1'b0) begin bad++;
      $display("FAIL abort_immediate got valid=%b result=%h ne=%b exp 0/0/0", bus.o_valid, bus.o_result, bus.o_flag_notequal); end
    @(negedge clk); rst = 1'b0;
    issue(4'h0, 32'h0000_FFFF, 32'h0000_0001, 5'd0, lat, rs);
    total++; if (bus.o_result !== 32'h0001_0000 || lat !== 1) begin bad++;
      $display("FAIL abort_fresh_add got result=%h lat=%0d exp result=00010000 lat=1", bus.o_result, lat); end
    release_result();
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_muldiv();
    test_hold();
    test_back_to_back();
    test_reset_abort();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
